// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the asynchronous FIFO pointer/flag blocks (read side
// and write side).
//   FIFO_ASIZE        default address width (depth = 2**FIFO_ASIZE)
//   FIFO_SYNC_STAGES  default depth of the cross-domain pointer synchroniser
//   GRAY_MAX_W        width of the Gray/binary helper functions; callers
//                     zero-extend their pointer into it and truncate the result
//   gray2bin()        Gray -> binary, MSB-first XOR prefix
//   bin2gray()        binary -> Gray
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_ASIZE       = 4;
    localparam int FIFO_SYNC_STAGES = 2;
    localparam int GRAY_MAX_W       = 32;

    // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
    // Zero-extended upper bits contribute nothing, so a narrow pointer
    // converts correctly inside the wide container.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
        logic [GRAY_MAX_W-1:0] bin;
        bin                 = '0;
        bin[GRAY_MAX_W-1]   = gray[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return (bin >> 1) ^ bin;
    endfunction

endpackage

// File: rtl/rptr_empty_ctrl_sync_bus.sv
// -----------------------------------------------------------------------------
// sync_bus
// Multi-flop synchroniser for a Gray-coded bus entering the clk_i domain.
// Only one bit of the bus changes per source update, so each stage samples a
// coherent value (old or new) even when the capture edge lands mid-change.
// Ports:
//   clk_i   destination clock
//   rst_ni  asynchronous active-low reset, clears every stage to 0
//   d_i     bus from the foreign clock domain
//   q_o     synchronised bus (last stage)
// -----------------------------------------------------------------------------
module sync_bus #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // NOTE: flop state is written with non-blocking assignments so every stage
    // samples its predecessor's value from before the edge; blocking here would
    // collapse the chain into a single flop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: this register array is a flop chain, not a RAM, so it is
            // reset; a real memory array would be left unreset.
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/rptr_empty_ctrl.sv
// -----------------------------------------------------------------------------
// rptr_empty_ctrl
// Read-side pointer and flag logic of an asynchronous FIFO.
// Ports:
//   rclk        read clock
//   rrst_n      asynchronous active-low reset
//   rinc        read request; ignored (and flagged) while the FIFO is empty
//   wptr_async  Gray write pointer straight from the write domain
//   aempty_thr  almost-empty threshold (quasi-static)
//   rclr_uf     clears the sticky underflow flag
//   rptr        Gray read pointer for the write domain
//   raddr       binary RAM read address
//   rempty      FIFO empty
//   raempty     fill level <= aempty_thr
//   rlevel      fill level as seen from the read domain, 0..2**ASIZE
//   runderflow  sticky read-while-empty error
// All outputs come straight from flops (raddr is a slice of one), so no
// combinational path exists from wptr_async to an output.
// -----------------------------------------------------------------------------
module rptr_empty_ctrl
    import fifo_pkg::*;
#(
    parameter int ASIZE       = FIFO_ASIZE,
    parameter int SYNC_STAGES = FIFO_SYNC_STAGES
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rinc,
    input  logic [ASIZE:0]   wptr_async,
    input  logic [ASIZE:0]   aempty_thr,
    input  logic             rclr_uf,
    output logic [ASIZE:0]   rptr,
    output logic [ASIZE-1:0] raddr,
    output logic             rempty,
    output logic             raempty,
    output logic [ASIZE:0]   rlevel,
    output logic             runderflow
);

    localparam int PW = ASIZE + 1;

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("rptr_empty_ctrl: SYNC_STAGES must be in 2..4");
    end

    logic [ASIZE:0] wptr_sync;
    logic [ASIZE:0] wbin_sync;

    logic [ASIZE:0] rbin_q,  rbin_d;
    logic [ASIZE:0] rptr_q,  rptr_d;
    logic [ASIZE:0] rlevel_q, rlevel_d;
    logic           rempty_q,     rempty_d;
    logic           raempty_q,    raempty_d;
    logic           runderflow_q, runderflow_d;

    logic           rd_en;
    logic           uf_event;

    sync_bus #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clk_i  (rclk),
        .rst_ni (rrst_n),
        .d_i    (wptr_async),
        .q_o    (wptr_sync)
    );

    // NOTE: every signal driven here is assigned on every pass, so no latch
    // can be inferred.
    always_comb begin
        rd_en    = rinc & ~rempty_q;
        uf_event = rinc &  rempty_q;

        // Pointer arithmetic is modulo 2**PW; the extra MSB tells wrap laps apart.
        rbin_d = rbin_q + PW'(rd_en);
        rptr_d = (rbin_d >> 1) ^ rbin_d;

        wbin_sync = PW'(gray2bin(GRAY_MAX_W'(wptr_sync)));

        // Compare against the next pointer so a read of the last entry shows
        // empty on the very edge that consumes it.
        rempty_d  = (rptr_d == wptr_sync);
        rlevel_d  = wbin_sync - rbin_d;
        raempty_d = (rlevel_d <= aempty_thr);

        // A new underflow wins over a clear in the same cycle.
        runderflow_d = uf_event | (runderflow_q & ~rclr_uf);
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q       <= '0;
            rptr_q       <= '0;
            rlevel_q     <= '0;
            rempty_q     <= 1'b1;
            raempty_q    <= 1'b1;
            runderflow_q <= 1'b0;
        end else begin
            rbin_q       <= rbin_d;
            rptr_q       <= rptr_d;
            rlevel_q     <= rlevel_d;
            rempty_q     <= rempty_d;
            raempty_q    <= raempty_d;
            runderflow_q <= runderflow_d;
        end
    end

    assign rptr       = rptr_q;
    assign raddr      = rbin_q[ASIZE-1:0];
    assign rempty     = rempty_q;
    assign raempty    = raempty_q;
    assign rlevel     = rlevel_q;
    assign runderflow = runderflow_q;

endmodule

// File: tb/tb_rptr_empty_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rptr_empty_ctrl
// Scoreboard bench for rptr_empty_ctrl (ASIZE=4, SYNC_STAGES=2). A
// count-based read-side model runs on binary counts and predicts the
// registered outputs for the next rclk edge. Each prediction is queued when
// stimulus is driven and popped/compared 1 time unit after that edge.
// -----------------------------------------------------------------------------
module tb_rptr_empty_ctrl;

    localparam int ASIZE = 4;

    typedef struct packed {
        logic [ASIZE:0]   rptr;
        logic [ASIZE-1:0] raddr;
        logic             rempty;
        logic             raempty;
        logic [ASIZE:0]   rlevel;
        logic             runderflow;
    } exp_t;

    logic             rclk;
    logic             rrst_n;
    logic             rinc;
    logic [ASIZE:0]   wptr_async;
    logic [ASIZE:0]   aempty_thr;
    logic             rclr_uf;
    logic [ASIZE:0]   rptr;
    logic [ASIZE-1:0] raddr;
    logic             rempty;
    logic             raempty;
    logic [ASIZE:0]   rlevel;
    logic             runderflow;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t exp_q[$];

    // Model state: binary read count, binary write count, two-stage delay of
    // the write count, registered empty and underflow.
    logic [ASIZE:0] m_rd, m_w, m_s1, m_s2;
    logic           m_empty, m_uf;

    rptr_empty_ctrl #(
        .ASIZE       (4),
        .SYNC_STAGES (2)
    ) dut (
        .rclk       (rclk),
        .rrst_n     (rrst_n),
        .rinc       (rinc),
        .wptr_async (wptr_async),
        .aempty_thr (aempty_thr),
        .rclr_uf    (rclr_uf),
        .rptr       (rptr),
        .raddr      (raddr),
        .rempty     (rempty),
        .raempty    (raempty),
        .rlevel     (rlevel),
        .runderflow (runderflow)
    );

    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    function automatic logic [ASIZE:0] gray5(input logic [ASIZE:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_step(output exp_t e);
        logic [ASIZE:0] nrd;
        nrd          = m_rd + ((rinc && !m_empty) ? 5'd1 : 5'd0);
        e.rptr       = gray5(nrd);
        e.raddr      = nrd[ASIZE-1:0];
        e.rempty     = (nrd == m_s2);
        e.rlevel     = m_s2 - nrd;
        e.raempty    = (e.rlevel <= aempty_thr);
        e.runderflow = (rinc && m_empty) || (m_uf && !rclr_uf);
        m_rd    = nrd;
        m_empty = e.rempty;
        m_uf    = e.runderflow;
        m_s2    = m_s1;
        m_s1    = m_w;
    endtask

    task automatic compare_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("rptr",       32'(rptr),       32'(e.rptr));
            check("raddr",      32'(raddr),      32'(e.raddr));
            check("rempty",     32'(rempty),     32'(e.rempty));
            check("raempty",    32'(raempty),    32'(e.raempty));
            check("rlevel",     32'(rlevel),     32'(e.rlevel));
            check("runderflow", 32'(runderflow), 32'(e.runderflow));
        end
    endtask

    // One read-clock cycle: drive, predict, clock, compare.
    task automatic cycle(input logic inc, input logic clr);
        exp_t e;
        rinc       = inc;
        rclr_uf    = clr;
        wptr_async = gray5(m_w);
        model_step(e);
        exp_q.push_back(e);
        @(posedge rclk);
        #1;
        compare_out();
    endtask

    // Asynchronous reset asserted mid-cycle; outputs are checked before the
    // next rclk edge. The write side is reset in the same event (m_w = 0).
    task automatic apply_reset(input string tag);
        #2;
        rrst_n = 1'b0;
        #1;
        check({tag, "_rptr"},       32'(rptr),       32'd0);
        check({tag, "_raddr"},      32'(raddr),      32'd0);
        check({tag, "_rempty"},     32'(rempty),     32'd1);
        check({tag, "_raempty"},    32'(raempty),    32'd1);
        check({tag, "_rlevel"},     32'(rlevel),     32'd0);
        check({tag, "_runderflow"}, 32'(runderflow), 32'd0);
        exp_q.delete();
        m_rd = '0; m_w = '0; m_s1 = '0; m_s2 = '0;
        m_empty = 1'b1; m_uf = 1'b0;
        rinc = 1'b0; rclr_uf = 1'b0; wptr_async = '0;
        repeat (2) @(posedge rclk);
        #1;
        rrst_n = 1'b1;
    endtask

    // Read whenever the model says data is present, until the read count
    // reaches target with the FIFO empty or the cycle budget expires.
    task automatic drain_to(input logic [ASIZE:0] target, input string tag);
        int budget;
        budget = 60;
        while (!(m_empty && m_rd == target) && budget > 0) begin
            cycle(!m_empty, 1'b0);
            budget--;
        end
        if (budget == 0) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        logic [ASIZE:0] prev_rptr;
        int             budget;

        rrst_n     = 1'b1;
        rinc       = 1'b0;
        rclr_uf    = 1'b0;
        wptr_async = '0;
        aempty_thr = 5'd2;

        // Power-on reset.
        apply_reset("por");

        // Reads on an empty FIFO: pointer frozen, sticky underflow.
        repeat (3) cycle(1'b1, 1'b0);
        check("uf_set",     32'(runderflow), 32'd1);
        check("uf_rptr",    32'(rptr),       32'd0);
        cycle(1'b0, 1'b1);
        check("uf_cleared", 32'(runderflow), 32'd0);
        cycle(1'b1, 1'b1);
        check("uf_set_wins_clr", 32'(runderflow), 32'd1);
        cycle(1'b0, 1'b1);

        // Five entries written: visible after sync + one flag cycle.
        m_w = 5'd5;
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        check("still_empty_2_edges", 32'(rempty), 32'd1);
        cycle(1'b0, 1'b0);
        check("lvl5",     32'(rlevel), 32'd5);
        check("nonempty", 32'(rempty), 32'd0);
        repeat (3) cycle(1'b1, 1'b0);
        check("lvl2",    32'(rlevel),  32'd2);
        check("aempty2", 32'(raempty), 32'd1);
        repeat (2) cycle(1'b1, 1'b0);
        check("drained_empty", 32'(rempty), 32'd1);
        check("drained_raddr", 32'(raddr),  32'd5);

        // Full FIFO from a fresh reset.
        apply_reset("rst2");
        m_w = 5'd16;
        repeat (3) cycle(1'b0, 1'b0);
        check("full_lvl",     32'(rlevel),  32'd16);
        check("full_rempty",  32'(rempty),  32'd0);
        check("full_raempty", 32'(raempty), 32'd0);
        aempty_thr = 5'd16;
        cycle(1'b0, 1'b0);
        check("thr16_raempty", 32'(raempty), 32'd1);
        aempty_thr = 5'd2;
        cycle(1'b1, 1'b1);
        check("full_read_lvl", 32'(rlevel),     32'd15);
        check("full_read_uf",  32'(runderflow), 32'd0);
        aempty_thr = 5'd0;
        cycle(1'b0, 1'b0);
        check("thr0_nonempty", 32'(raempty), 32'd0);

        // Advance to read count 30, then wrap past 31 -> 0 up to 19.
        drain_to(5'd16, "drain16");
        m_w = 5'd30;
        drain_to(5'd30, "drain30");
        check("at30_raddr", 32'(raddr), 32'd14);
        m_w = 5'd19;
        budget = 60;
        while (!(m_empty && m_rd == 5'd19) && budget > 0) begin
            prev_rptr = rptr;
            if (!m_empty) begin
                cycle(1'b1, 1'b0);
                check("gray_one_bit", 32'($countones(prev_rptr ^ rptr)), 32'd1);
            end else begin
                cycle(1'b0, 1'b0);
            end
            budget--;
        end
        if (budget == 0) check("wrap_timeout", 32'd0, 32'd1);
        check("wrap_empty",   32'(rempty),  32'd1);
        check("wrap_raddr",   32'(raddr),   32'd3);
        check("wrap_rptr",    32'(rptr),    32'd26);
        check("thr0_empty",   32'(raempty), 32'd1);

        // Reset mid-stream with seven entries pending.
        aempty_thr = 5'd2;
        m_w = 5'd26;
        repeat (3) cycle(1'b0, 1'b0);
        check("pre_rst_lvl7", 32'(rlevel), 32'd7);
        apply_reset("midrst");

        // Counting resumes right after reset release.
        m_w = 5'd3;
        repeat (3) cycle(1'b0, 1'b0);
        check("resume_lvl3", 32'(rlevel), 32'd3);
        repeat (3) cycle(1'b1, 1'b0);
        check("resume_empty", 32'(rempty), 32'd1);
        check("resume_raddr", 32'(raddr),  32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rptr_empty_ctrl.md
RPTR_EMPTY_CTRL -- requirements
Module: rptr_empty_ctrl

Interface
REQ-001 SHALL have parameter ASIZE, default 4, address width; FIFO depth = 2**ASIZE.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, write-pointer synchroniser depth; legal range 2..4.
REQ-003 SHALL have port rclk  input  1  read clock.
REQ-004 SHALL have port rrst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rinc  input  1  read request.
REQ-006 SHALL have port wptr_async  input  ASIZE+1  write pointer, Gray code, from write clock domain (unsynchronised).
REQ-007 SHALL have port aempty_thr  input  ASIZE+1  almost-empty threshold, quasi-static.
REQ-008 SHALL have port rclr_uf  input  1  clear for sticky underflow flag.
REQ-009 SHALL have port rptr  output  ASIZE+1  read pointer, Gray code, for the write domain.
REQ-010 SHALL have port raddr  output  ASIZE  binary RAM read address.
REQ-011 SHALL have port rempty  output  1  FIFO empty.
REQ-012 SHALL have port raempty  output  1  FIFO almost empty.
REQ-013 SHALL have port rlevel  output  ASIZE+1  fill level seen from the read domain, 0..2**ASIZE.
REQ-014 SHALL have port runderflow  output  1  sticky read-while-empty error.

Function
REQ-015 SHALL pass wptr_async through SYNC_STAGES rclk flops; last stage = wptr_sync; all stages reset to 0.
REQ-016 SHALL form rbnext = rbin + (rinc & ~rempty), modulo 2**(ASIZE+1), wrapping from all-ones to 0.
REQ-017 SHALL form rgnext = (rbnext >> 1) ^ rbnext and register rbin <= rbnext, rptr <= rgnext every cycle.
REQ-018 SHALL drive raddr = rbin[ASIZE-1:0] combinationally from the register.
REQ-019 SHALL register rempty <= (rgnext == wptr_sync).
REQ-020 SHALL convert wptr_sync to binary wbin_sync (Gray-to-binary, MSB-first XOR prefix).
REQ-021 SHALL register rlevel <= (wbin_sync - rbnext) mod 2**(ASIZE+1).
REQ-022 SHALL register raempty <= (lvlnext <= aempty_thr), where lvlnext is the value loaded into rlevel in the same cycle.
REQ-023 SHALL treat aempty_thr = 0 as raempty equivalent to rempty, and aempty_thr >= 2**ASIZE as raempty permanently 1.
REQ-024 SHALL, when rinc = 1 while rempty = 1, leave rbin/rptr unchanged and set runderflow on the next rclk edge.
REQ-025 SHALL hold runderflow until a cycle with rclr_uf = 1 and no new underflow event; a simultaneous set and clear SHALL leave runderflow = 1.
REQ-026 SHALL update all flags with one rclk latency from the synchronised write pointer; the total write-to-nonempty latency is SYNC_STAGES+1 rclk cycles.
REQ-027 SHALL allow a read on the final entry: rempty rises on the edge that consumes it (rgnext equals wptr_sync), with no extra cycle.

Reset
REQ-028 SHALL, on rrst_n low, immediately force rbin = 0, rptr = 0, sync stages = 0, rlevel = 0, rempty = 1, raempty = 1, runderflow = 0.
REQ-029 SHALL, for reset asserted mid-operation, discard the read position; the write side must be reset in the same reset event.
REQ-030 SHALL resume normal counting on the first rclk edge after rrst_n deasserts.

Structure
REQ-031 SHALL place the ASIZE/SYNC_STAGES defaults and a Gray-to-binary function in the shared fifo package, also used by the write-side block.
REQ-032 SHALL implement the synchroniser as sub-module sync_bus (parameters WIDTH, STAGES, asynchronous active-low reset).
REQ-033 SHALL contain no combinational path from wptr_async to any output.

Verification (ASIZE=4, SYNC_STAGES=2)
REQ-034 Reset, then wptr_async=0 and rinc=1 for 3 cycles -> rempty=1, raempty=1, rptr=0, runderflow=1 from the first edge after rinc; pulse rclr_uf with rinc=0 -> runderflow=0.
REQ-035 wptr_async steps to Gray(5), aempty_thr=2 -> rempty falls and rlevel=5 after 3 edges; then 3 reads -> rlevel=2, raempty=1; 2 more reads -> rempty=1, raddr=5.
REQ-036 Wrap: write pointer advances to Gray(16+3) while rbin=30, reading continuously -> rbin wraps 31->0, rptr follows the Gray sequence with 1 bit change per step, and rempty rises at rbin=19.
REQ-037 Full: wptr=Gray(16) with rbin=0 -> rlevel=16, rempty=0, raempty=0 (thr=2); a read on the same cycle as rclr_uf=1 and underflow=0 -> rlevel=15.
REQ-038 Assert rrst_n low mid-stream with rlevel=7 -> all outputs are at their reset values before the next rclk edge.
